// File: rtl/fir_sample_history.sv
// Multichannel circular sample history for a time-multiplexed FIR MAC.
// Each accepted sample is stored, then the channel's full history streams out newest first.
module fir_sample_history #(
  parameter int unsigned N    = 8,
  parameter int unsigned TAPS = 32,
  parameter int unsigned CH   = 1,
  localparam int unsigned AW  = $clog2(TAPS),
  localparam int unsigned CW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_tap,
  output logic [CW-1:0] out_ch,
  output logic          out_last,
  output logic          err
);

  localparam int unsigned Depth = CH * TAPS;
  localparam int unsigned RAW   = $clog2(Depth);

  localparam logic [AW-1:0]  LastTap  = AW'(TAPS - 1);
  localparam logic [AW-1:0]  TapsMod  = AW'(TAPS);
  localparam logic [RAW-1:0] LastAddr = RAW'(Depth - 1);

  typedef enum logic [1:0] {StClear, StIdle, StStream} state_e;

  state_e state_q, state_d;

  logic [N-1:0]   mem [Depth];
  logic [AW-1:0]  wp_q [CH];
  logic [RAW-1:0] clr_addr_q;
  logic [CW-1:0]  ch_q;
  logic [AW-1:0]  base_q;
  logic [AW-1:0]  k_q;
  logic [N-1:0]   rd_q;
  logic           out_valid_q, out_last_q, err_q;
  logic [AW-1:0]  out_tap_q;
  logic [CW-1:0]  out_ch_q;

  logic           flush, ch_ok, accept, push, rd_en, wr_en;
  logic [CW-1:0]  wr_ch;
  logic [AW-1:0]  wp_cur, wp_next, rd_idx;
  logic [RAW-1:0] rd_addr, wr_addr;
  logic [N-1:0]   wr_data;

  assign flush    = rst | clr;
  assign in_ready = (state_q == StIdle);
  assign ch_ok    = 32'(in_ch) < CH;
  // Clamp so an out-of-range channel never indexes past the pointer array.
  assign wr_ch    = ch_ok ? in_ch : '0;
  assign accept   = !flush && in_valid && in_ready;
  assign push     = accept && ch_ok;
  assign wp_cur   = wp_q[wr_ch];
  assign wp_next  = (wp_cur == LastTap) ? '0 : wp_cur + 1'b1;

  // Modular (base - k) for any TAPS; the truncated TapsMod still wraps correctly.
  assign rd_idx  = (base_q >= k_q) ? base_q - k_q : base_q + TapsMod - k_q;
  assign rd_addr = RAW'(32'(ch_q) * TAPS + 32'(rd_idx));
  assign rd_en   = (state_q == StStream) && !flush;

  assign wr_en   = (state_q == StClear) || push;
  assign wr_addr = (state_q == StClear) ? clr_addr_q : RAW'(32'(wr_ch) * TAPS + 32'(wp_cur));
  assign wr_data = (state_q == StClear) ? '0 : in_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StClear:  if (clr_addr_q == LastAddr) state_d = StIdle;
      StIdle:   if (push) state_d = StStream;
      StStream: if (k_q == LastTap) state_d = StIdle;
      default:  state_d = StClear;
    endcase
    if (flush) state_d = StClear;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StClear;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (flush)      rd_q <= '0;
    else if (rd_en) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      clr_addr_q  <= '0;
      ch_q        <= '0;
      base_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_tap_q   <= '0;
      out_ch_q    <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(CH); i++) wp_q[i] <= '0;
    end else begin
      if (state_q == StClear) clr_addr_q <= clr_addr_q + 1'b1;
      if (push) begin
        wp_q[wr_ch] <= wp_next;
        ch_q        <= in_ch;
        base_q      <= wp_cur;
        k_q         <= '0;
      end else if (state_q == StStream) begin
        k_q <= k_q + 1'b1;
      end
      out_valid_q <= rd_en;
      out_last_q  <= rd_en && (k_q == LastTap);
      err_q       <= accept && !ch_ok;
      if (rd_en) begin
        out_tap_q <= k_q;
        out_ch_q  <= ch_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = rd_q;
  assign out_tap   = out_tap_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fir_sample_history.sv
// Directed bench for fir_sample_history with TAPS=5, CH=3 against a shift-register history model.
module tb_fir_sample_history;

  localparam int unsigned N    = 8;
  localparam int unsigned TAPS = 5;
  localparam int unsigned CH   = 3;
  localparam int unsigned AW   = 3;
  localparam int unsigned CW   = 2;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, in_ready;
  logic [CW-1:0] in_ch;
  logic [N-1:0]  in_data;
  logic          out_valid, out_last, err;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_tap;
  logic [CW-1:0] out_ch;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] hist [CH][TAPS];

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [AW-1:0] tap;
    logic [N-1:0]  data;
    logic          last;
  } beat_t;

  fir_sample_history #(.N(N), .TAPS(TAPS), .CH(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_tap  (out_tap),
    .out_ch   (out_ch),
    .out_last (out_last),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < int'(CH); c++)
      for (int k = 0; k < int'(TAPS); k++) hist[c][k] = '0;
  endtask

  task automatic model_push(int ch, logic [N-1:0] d);
    for (int k = int'(TAPS) - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = d;
  endtask

  task automatic wait_ready(string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: got in_ready=%b want 1", name, in_ready);
    end
  endtask

  // Counts cycles in_ready stays low after a clear/reset edge.
  task automatic count_clear(string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != int'(CH * TAPS)) begin
      errors++;
      $display("FAIL %s clear_len: got %0d cycles want %0d", name, n, CH * TAPS);
    end
  endtask

  task automatic send_sample(int ch, logic [N-1:0] d, string name);
    logic [15:0] got, want;
    wait_ready(name);
    in_valid = 1'b1;
    in_ch    = CW'(ch);
    in_data  = d;
    tick();
    in_valid = 1'b0;
    model_push(ch, d);
    checks++;
    if ({out_valid, in_ready, err} !== 3'b000) begin
      errors++;
      $display("FAIL %s gap_cycle: got valid/ready/err=%b want 000", name,
               {out_valid, in_ready, err});
    end
    for (int k = 0; k < int'(TAPS); k++) begin
      tick();
      got  = {out_valid, out_tap, out_ch, out_data, out_last, in_ready};
      want = {1'b1, AW'(k), CW'(ch), hist[ch][k], k == int'(TAPS) - 1, k == int'(TAPS) - 1};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s tap%0d: got %h want %h (valid,tap,ch,data,last,ready)",
                 name, k, got, want);
      end
    end
    tick();
    checks++;
    if ({out_valid, out_last, out_data} !== {2'b00, hist[ch][TAPS-1]}) begin
      errors++;
      $display("FAIL %s hold: got valid=%b last=%b data=%h want 0 0 %h", name,
               out_valid, out_last, out_data, hist[ch][TAPS-1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_last, err, out_data, out_tap, out_ch, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b e=%b d=%h t=%0d c=%0d r=%b want all 0",
               out_valid, out_last, err, out_data, out_tap, out_ch, in_ready);
    end
    count_clear("reset");
    model_clear();
  endtask

  task automatic test_first_stream();
    send_sample(0, 8'd7, "first_stream");
  endtask

  task automatic test_wrap();
    for (int v = 1; v <= 7; v++) send_sample(0, N'(v), "wrap");
    checks++;
    if ({hist[0][0], hist[0][4]} !== {8'd7, 8'd3}) begin
      errors++;
      $display("FAIL wrap_model: got %h want 0703", {hist[0][0], hist[0][4]});
    end
  endtask

  task automatic test_isolation();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    count_clear("clr_pulse");
    model_clear();
    send_sample(0, 8'd10, "iso_ch0");
    send_sample(2, 8'd20, "iso_ch2");
    send_sample(0, 8'd11, "iso_ch0");
    send_sample(2, 8'd21, "iso_ch2");
    send_sample(0, 8'd12, "iso_ch0");
    send_sample(1, 8'd30, "iso_ch1");
  endtask

  task automatic test_invalid_ch();
    wait_ready("invalid_ch");
    in_valid = 1'b1;
    in_ch    = 2'd3;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({err, out_valid, in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL invalid_pulse: got err/valid/ready=%b want 101", {err, out_valid, in_ready});
    end
    tick();
    checks++;
    if ({err, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL invalid_after: got err/valid=%b want 00", {err, out_valid});
    end
    send_sample(0, 8'd13, "invalid_next");
  endtask

  task automatic test_mid_clear();
    wait_ready("mid_clear");
    in_valid = 1'b1;
    in_ch    = 2'd1;
    in_data  = 8'd40;
    tick();
    in_valid = 1'b0;
    model_push(1, 8'd40);
    repeat (3) tick();
    checks++;
    if ({out_valid, out_tap, out_ch, out_data} !== {1'b1, 3'd2, 2'd1, hist[1][2]}) begin
      errors++;
      $display("FAIL mid_tap2: got v=%b t=%0d c=%0d d=%h want 1 2 1 %h",
               out_valid, out_tap, out_ch, out_data, hist[1][2]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if ({out_valid, out_last, out_data, out_tap, out_ch, in_ready} !== '0) begin
      errors++;
      $display("FAIL mid_abort: got v=%b l=%b d=%h t=%0d c=%0d r=%b want all 0",
               out_valid, out_last, out_data, out_tap, out_ch, in_ready);
    end
    count_clear("mid_clear");
    model_clear();
    send_sample(1, 8'd41, "after_clear");
  endtask

  task automatic test_back_to_back();
    beat_t q[$];
    beat_t b;
    int j = 0, cyc = 0, last_acc = -1;
    int cur_ch;
    logic [N-1:0] cur_data;
    logic acc;
    cur_ch   = $urandom_range(0, 2);
    cur_data = N'($urandom);
    in_valid = 1'b1;
    in_ch    = CW'(cur_ch);
    in_data  = cur_data;
    while ((j < 100 || q.size() > 0) && cyc < 1000) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious: got out_valid=1 want 0 at cycle %0d", cyc);
        end else begin
          b = q.pop_front();
          if ({out_ch, out_tap, out_data, out_last} !== b) begin
            errors++;
            $display("FAIL b2b_beat: got ch=%0d tap=%0d d=%h last=%b want %0d %0d %h %b",
                     out_ch, out_tap, out_data, out_last, b.ch, b.tap, b.data, b.last);
          end
        end
      end
      acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (acc) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != int'(TAPS) + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", cyc - last_acc, TAPS + 1);
          end
        end
        last_acc = cyc;
        model_push(cur_ch, cur_data);
        for (int k = 0; k < int'(TAPS); k++)
          q.push_back('{ch: CW'(cur_ch), tap: AW'(k), data: hist[cur_ch][k],
                        last: (k == int'(TAPS) - 1)});
        j++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (j < 100) begin
          cur_ch   = $urandom_range(0, 2);
          cur_data = N'($urandom);
          in_ch    = CW'(cur_ch);
          in_data  = cur_data;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (j != 100 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_complete: got %0d accepted, %0d beats pending want 100, 0", j, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_stream();
    test_wrap();
    test_isolation();
    test_invalid_ch();
    test_mid_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
